me_search_ctrl: RTL and testbench

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

---
 rtl/me_pkg.sv | 20 ++
 rtl/me_search_ctrl_if.sv | 23 ++
 rtl/me_min_tracker.sv | 53 +++++
 rtl/me_search_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared types for the motion-estimation search controller: FSM states and
// array shift command encodings.
package me_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SH_HOLD = 2'b00,
    SH_DOWN = 2'b01,
    SH_UP   = 2'b10,
    SH_LEFT = 2'b11
  } shift_cmd_t;

endpackage

// File: rtl/me_search_ctrl_if.sv
// Result handshake bundle: best motion vector and SAD, valid/ready.
interface me_search_ctrl_if #(
  parameter int SAD_W = 16,
  parameter int MV_W  = 6
) ();

  logic                    out_valid;
  logic                    out_ready;
  logic signed [MV_W-1:0]  mv_x;
  logic signed [MV_W-1:0]  mv_y;
  logic [SAD_W-1:0]        min_sad;

  modport master (
    output out_valid, mv_x, mv_y, min_sad,
    input  out_ready
  );

  modport slave (
    input  out_valid, mv_x, mv_y, min_sad,
    output out_ready
  );

endinterface

// File: rtl/me_min_tracker.sv
// Running minimum of candidate SADs; holds best SAD and its signed motion vector.
module me_min_tracker #(
  parameter int SAD_W = 16,
  parameter int MV_W  = 6,
  parameter int CW    = 3,
  parameter int N     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   cmp_vld_i,
  input  logic [SAD_W-1:0]       sad_i,
  input  logic [CW-1:0]          col_i,
  input  logic [CW-1:0]          row_i,
  output logic [SAD_W-1:0]       min_sad_o,
  output logic signed [MV_W-1:0] mv_x_o,
  output logic signed [MV_W-1:0] mv_y_o
);

  localparam int unsigned HALF = (N - 1) / 2;

  logic                   have_q;
  logic [SAD_W-1:0]       min_sad_q;
  logic signed [MV_W-1:0] mv_x_q, mv_y_q;
  logic                   take;
  logic signed [MV_W-1:0] cand_x, cand_y;

  // Strict less-than keeps the earliest of equal SADs; have_q forces the first load.
  always_comb begin
    take   = cmp_vld_i && (!have_q || (sad_i < min_sad_q));
    cand_x = MV_W'(col_i) - MV_W'(HALF);
    cand_y = MV_W'(row_i) - MV_W'(HALF);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      have_q    <= 1'b0;
      min_sad_q <= '1;
      mv_x_q    <= '0;
      mv_y_q    <= '0;
    end else if (take) begin
      have_q    <= 1'b1;
      min_sad_q <= sad_i;
      mv_x_q    <= cand_x;
      mv_y_q    <= cand_y;
    end
  end

  assign min_sad_o = min_sad_q;
  assign mv_x_o    = mv_x_q;
  assign mv_y_o    = mv_y_q;

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation controller: loads arrays, snakes over N*N candidates,
// tracks the minimum SAD. Define ME_EARLY_TERM_EN to add sad_thresh_i early termination.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 32,
  parameter int SAD_W      = 16,
  parameter int SUM_LAT    = 2,
  parameter int MV_W       = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
`ifdef ME_EARLY_TERM_EN
  input  logic [SAD_W-1:0]             sad_thresh_i,
`endif
  input  logic [SAD_W-1:0]             sad_in_i,
  output logic                         busy_o,
  output logic                         spr_en_o,
  output logic                         cpr_en_o,
  output logic [$clog2(MACRO_DIM)-1:0] load_row_o,
  output logic [1:0]                   shift_cmd_o,
  me_search_ctrl_if.master             res
);

  localparam int unsigned N   = SEARCH_DIM - MACRO_DIM + 1;
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned LRW = $clog2(MACRO_DIM);
  localparam int unsigned DW  = $clog2(SUM_LAT) + 1;

  state_t          state_q, state_d;
  logic [LRW-1:0]  lcnt_q, lcnt_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  shift_cmd_t      sh;

  logic            dl_vld_q [SUM_LAT];
  logic [CW-1:0]   dl_col_q [SUM_LAT];
  logic [CW-1:0]   dl_row_q [SUM_LAT];

  logic            row_at_end;
  logic            last_cand;
  logic            early_stop;
  logic            search_start;

  logic [SAD_W-1:0]       min_sad;
  logic signed [MV_W-1:0] mv_x, mv_y;

  // Even columns walk downwards, odd columns upwards.
  assign row_at_end   = col_q[0] ? (row_q == '0) : (row_q == CW'(N - 1));
  assign last_cand    = (col_q == CW'(N - 1)) && row_at_end;
  assign search_start = (state_q == ST_IDLE) && start_i;

`ifdef ME_EARLY_TERM_EN
  assign early_stop = (state_q == ST_SEARCH) && dl_vld_q[SUM_LAT-1] &&
                      (sad_in_i < sad_thresh_i);
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    col_d      = col_q;
    row_d      = row_q;
    dcnt_d     = dcnt_q;
    spr_en_o   = 1'b0;
    cpr_en_o   = 1'b0;
    load_row_o = '0;
    sh         = SH_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          lcnt_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_LOAD: begin
        spr_en_o   = 1'b1;
        cpr_en_o   = 1'b1;
        load_row_o = lcnt_q;
        if (lcnt_q == LRW'(MACRO_DIM - 1)) state_d = ST_SEARCH;
        else                                lcnt_d  = lcnt_q + 1'b1;
      end
      ST_SEARCH: begin
        spr_en_o = 1'b1;
        if (last_cand) begin
          sh      = SH_HOLD;
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else if (row_at_end) begin
          sh    = SH_LEFT;
          col_d = (col_q == CW'(N - 1)) ? col_q : col_q + 1'b1;
        end else if (!col_q[0]) begin
          sh    = SH_DOWN;
          row_d = (row_q == CW'(N - 1)) ? row_q : row_q + 1'b1;
        end else begin
          sh    = SH_UP;
          row_d = (row_q == '0) ? row_q : row_q - 1'b1;
        end
        if (early_stop) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DW'(SUM_LAT - 1)) state_d = ST_DONE;
        else                             dcnt_d  = dcnt_q + 1'b1;
      end
      ST_DONE: begin
        if (res.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign shift_cmd_o = sh;

  // Candidate coordinates travel alongside the adder tree latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SUM_LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_col_q[i] <= '0;
        dl_row_q[i] <= '0;
      end
    end else begin
      dl_vld_q[0] <= (state_q == ST_SEARCH);
      dl_col_q[0] <= col_q;
      dl_row_q[0] <= row_q;
      for (int unsigned i = 1; i < SUM_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_col_q[i] <= dl_col_q[i-1];
        dl_row_q[i] <= dl_row_q[i-1];
      end
    end
  end

  me_min_tracker #(
    .SAD_W (SAD_W),
    .MV_W  (MV_W),
    .CW    (CW),
    .N     (N)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (search_start),
    .cmp_vld_i (dl_vld_q[SUM_LAT-1]),
    .sad_i     (sad_in_i),
    .col_i     (dl_col_q[SUM_LAT-1]),
    .row_i     (dl_row_q[SUM_LAT-1]),
    .min_sad_o (min_sad),
    .mv_x_o    (mv_x),
    .mv_y_o    (mv_y)
  );

  assign res.out_valid = (state_q == ST_DONE);
  assign res.min_sad   = min_sad;
  assign res.mv_x      = mv_x;
  assign res.mv_y      = mv_y;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl with MACRO_DIM=4, SEARCH_DIM=8 (N=5), SUM_LAT=2.
module tb_me_search_ctrl;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] sad_in_i;
  logic [15:0] sad_thresh_i;
  logic        busy_o, spr_en_o, cpr_en_o;
  logic [1:0]  load_row_o;
  logic [1:0]  shift_cmd_o;

  int nvec = 0;
  int nmis = 0;

  me_search_ctrl_if #(.SAD_W(16), .MV_W(6)) rif ();

  me_search_ctrl #(
    .MACRO_DIM  (4),
    .SEARCH_DIM (8),
    .SAD_W      (16),
    .SUM_LAT    (2),
    .MV_W       (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
`ifdef ME_EARLY_TERM_EN
    .sad_thresh_i (sad_thresh_i),
`endif
    .sad_in_i     (sad_in_i),
    .busy_o       (busy_o),
    .spr_en_o     (spr_en_o),
    .cpr_en_o     (cpr_en_o),
    .load_row_o   (load_row_o),
    .shift_cmd_o  (shift_cmd_o),
    .res          (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_shift(input int idx);
    if (idx == N*N - 1)    return 2'b00;
    if (idx % N == N - 1)  return 2'b11;
    return ((idx / N) % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_busy"},     int'(busy_o),        0);
    chk({pfx, "_valid"},    int'(rif.out_valid), 0);
    chk({pfx, "_spr"},      int'(spr_en_o),      0);
    chk({pfx, "_cpr"},      int'(cpr_en_o),      0);
    chk({pfx, "_shift"},    int'(shift_cmd_o),   0);
    chk({pfx, "_load_row"}, int'(load_row_o),    0);
    chk({pfx, "_mv_x"},     int'(rif.mv_x),      0);
    chk({pfx, "_mv_y"},     int'(rif.mv_y),      0);
    chk({pfx, "_min_sad"},  int'(rif.min_sad),   65535);
  endtask

  // Start a search and run until out_valid; sad for scan index s is driven in cycle s+7.
  task automatic run_search(input int hot, input logic [15:0] hot_sad, input logic [15:0] base,
                            output int vcyc, output int n_search, output int snake_err,
                            output int n_load, output int load_err);
    int k;
    int s;
    vcyc = -1; n_search = 0; snake_err = 0; n_load = 0; load_err = 0;
    start_i  = 1'b1;
    sad_in_i = base;
    step();
    start_i = 1'b0;
    k = 1;
    while (k <= 80 && vcyc < 0) begin
      s = k - 7;
      sad_in_i = (s == hot) ? hot_sad : base;
      if (cpr_en_o) begin
        n_load++;
        if (int'(load_row_o) != k - 1 || shift_cmd_o != 2'b00) load_err++;
      end
      if (spr_en_o && !cpr_en_o) begin
        if (shift_cmd_o != exp_shift(k - 5)) snake_err++;
        n_search++;
      end
      if (rif.out_valid) vcyc = k;
      else begin
        step();
        k++;
      end
    end
  endtask

  task automatic handshake(input string pfx);
    rif.out_ready = 1'b1;
    step();
    rif.out_ready = 1'b0;
    chk({pfx, "_idle_after_hs"}, int'(busy_o), 0);
  endtask

  initial begin
    int vc, ns, se, nl, le;
    int hold_err;
    rst = 1'b1; start_i = 1'b0; sad_in_i = '0; sad_thresh_i = '0; rif.out_ready = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    rst = 1'b0;
    step();

    // Best candidate (col 3,row 1) sits at scan index 18.
    run_search(18, 16'd5, 16'd100, vc, ns, se, nl, le);
    chk("t1_valid_cycle", vc, 32);
    chk("t1_mv_x", int'(rif.mv_x), 1);
    chk("t1_mv_y", int'(rif.mv_y), -1);
    chk("t1_min_sad", int'(rif.min_sad), 5);
    chk("t1_search_cycles", ns, 25);
    chk("t1_snake_err", se, 0);
    chk("t1_load_cycles", nl, 4);
    chk("t1_load_err", le, 0);

    // Back-pressure in DONE with start pulses that must be ignored.
    hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      start_i = (i % 2 == 0);
      step();
      if (!rif.out_valid || !busy_o || int'(rif.mv_x) != 1 || int'(rif.mv_y) != -1 ||
          int'(rif.min_sad) != 5 || spr_en_o || cpr_en_o) hold_err++;
    end
    chk("t1_done_hold_err", hold_err, 0);
    start_i = 1'b1;
    handshake("t1");
    start_i = 1'b0;
    step();
    chk("t1_start_on_hs_ignored", int'(busy_o), 0);

    // All equal: first candidate (0,0) wins.
    run_search(-1, 16'd0, 16'd50, vc, ns, se, nl, le);
    chk("t2_valid_cycle", vc, 32);
    chk("t2_mv_x", int'(rif.mv_x), -2);
    chk("t2_mv_y", int'(rif.mv_y), -2);
    chk("t2_min_sad", int'(rif.min_sad), 50);
    handshake("t2");

    // All-ones SADs still load the first candidate.
    run_search(-1, 16'd0, 16'hFFFF, vc, ns, se, nl, le);
    chk("t3_mv_x", int'(rif.mv_x), -2);
    chk("t3_mv_y", int'(rif.mv_y), -2);
    chk("t3_min_sad", int'(rif.min_sad), 65535);
    handshake("t3");

    // Final scan index 24 is (4,4), compared during DRAIN.
    run_search(24, 16'd7, 16'd50, vc, ns, se, nl, le);
    chk("t4_valid_cycle", vc, 32);
    chk("t4_mv_x", int'(rif.mv_x), 2);
    chk("t4_mv_y", int'(rif.mv_y), 2);
    chk("t4_min_sad", int'(rif.min_sad), 7);
    handshake("t4");

    // Reset during the 7th SEARCH cycle (cycle 11 after start).
    start_i = 1'b1;
    sad_in_i = 16'd3;
    step();
    start_i = 1'b0;
    repeat (10) step();
    chk("t5_in_search", int'(spr_en_o && !cpr_en_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("t5");
    hold_err = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy_o || rif.out_valid) hold_err++;
    end
    chk("t5_no_valid_after_abort", hold_err, 0);
    run_search(18, 16'd5, 16'd100, vc, ns, se, nl, le);
    chk("t5_valid_cycle", vc, 32);
    chk("t5_search_cycles", ns, 25);
    chk("t5_mv_x", int'(rif.mv_x), 1);
    chk("t5_mv_y", int'(rif.mv_y), -1);
    chk("t5_min_sad", int'(rif.min_sad), 5);
    handshake("t5");

`ifdef ME_EARLY_TERM_EN
    // Index 3 is (0,3); compared in cycle 10, DRAIN 11-12, DONE in 13.
    sad_thresh_i = 16'd10;
    run_search(3, 16'd4, 16'd100, vc, ns, se, nl, le);
    chk("t6_valid_cycle", vc, 13);
    chk("t6_mv_x", int'(rif.mv_x), -2);
    chk("t6_mv_y", int'(rif.mv_y), 1);
    chk("t6_min_sad", int'(rif.min_sad), 4);
    handshake("t6");
    sad_thresh_i = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
